br_gen_frac: RTL and testbench

- Parametrised fractional baud-rate generator; successor to the fixed integer tick generator used by the UART.
- Produces an oversampling tick (o_tick, for RX sampling) and a bit-rate tick (o_bit_tick, for TX shifting).
- Divisor is runtime-programmable, with an integer part plus a fractional part (fractional-N accumulator), so the average tick rate tracks the requested baud rate with no cumulative error.
- Supports a phase re-sync for RX start-bit alignment.

---
 rtl/br_gen_frac.sv | 135 +++++++++++++
 tb/tb_br_gen_frac.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/br_gen_frac.sv
// Fractional baud-rate generator.
// An integer down-counter sets the o_tick period. A fractional accumulator adds one
// extra clock whenever it overflows, so the average period is int + frac/2^FRAC_NBITS.
// A second counter divides o_tick by OVERSAMPLE to produce o_bit_tick.
// A new divisor is held in a shadow register and only takes effect at a period
// boundary, so any period in progress always runs to completion.
module br_gen_frac #(
    parameter real CLOCK_FREQUENCY = 50.0E6,
    parameter int  BAUD_RATE       = 19200,
    parameter int  OVERSAMPLE      = 16,
    parameter int  INT_NBITS       = 12,
    parameter int  FRAC_NBITS      = 4
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic [INT_NBITS-1:0]  i_div_int,
    input  logic [FRAC_NBITS-1:0] i_div_frac,
    input  logic                  i_load,
    input  logic                  i_resync,
    output logic                  o_tick,
    output logic                  o_bit_tick,
    output logic                  o_pending
);

    localparam int OS_NBITS = $clog2(OVERSAMPLE);
    localparam int DEF_DIV  = $rtoi(CLOCK_FREQUENCY * (2.0 ** FRAC_NBITS)
                                    / (OVERSAMPLE * BAUD_RATE) + 0.5);
    localparam logic [INT_NBITS-1:0]  DEF_INT  = INT_NBITS'(DEF_DIV >> FRAC_NBITS);
    localparam logic [FRAC_NBITS-1:0] DEF_FRAC = FRAC_NBITS'(DEF_DIV % (2 ** FRAC_NBITS));
    localparam logic [OS_NBITS-1:0]   OS_LAST  = OS_NBITS'(OVERSAMPLE - 1);
    localparam logic [OS_NBITS-1:0]   OS_HALF  = OS_NBITS'(OVERSAMPLE / 2 - 1);

    logic [INT_NBITS-1:0]  r_act_int;
    logic [FRAC_NBITS-1:0] r_act_frac;
    logic [INT_NBITS-1:0]  r_sh_int;
    logic [FRAC_NBITS-1:0] r_sh_frac;
    logic                  r_pending;
    logic [INT_NBITS-1:0]  r_cnt;
    logic [FRAC_NBITS-1:0] r_acc;
    logic [OS_NBITS-1:0]   r_os;
    logic                  r_tick;
    logic                  r_bit_tick;

    logic [INT_NBITS-1:0]  w_ld_int;
    logic [INT_NBITS-1:0]  w_use_int;
    logic [FRAC_NBITS-1:0] w_use_frac;
    logic [FRAC_NBITS-1:0] w_acc_base;
    logic [FRAC_NBITS:0]   w_sum;
    logic [INT_NBITS-1:0]  w_start_cnt;
    logic [INT_NBITS-1:0]  w_reload_cnt;
    logic                  w_reload;
    logic                  w_apply;

    // Divisor actually used this cycle: the shadow value if a load is waiting.
    // A period of 1 clock would leave no idle cycle between ticks, hence the floor of 2.
    always_comb begin
        w_ld_int     = (i_div_int < INT_NBITS'(2)) ? INT_NBITS'(2) : i_div_int;
        w_use_int    = r_pending ? r_sh_int  : r_act_int;
        w_use_frac   = r_pending ? r_sh_frac : r_act_frac;
        w_acc_base   = r_pending ? '0 : r_acc;
        w_sum        = {1'b0, w_acc_base} + {1'b0, w_use_frac};
        w_start_cnt  = w_use_int - INT_NBITS'(1);
        w_reload_cnt = w_start_cnt + {{(INT_NBITS-1){1'b0}}, w_sum[FRAC_NBITS]};
        w_reload     = i_enable && (r_cnt == '0);
        w_apply      = r_pending && (i_resync || !i_enable || w_reload);
    end

    // Shadow capture and hand-over to the active divisor.
    // On a cycle that both captures and applies, the older shadow is applied first and
    // the new capture stays pending until the next boundary.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_act_int  <= DEF_INT;
            r_act_frac <= DEF_FRAC;
            r_sh_int   <= DEF_INT;
            r_sh_frac  <= DEF_FRAC;
            r_pending  <= 1'b0;
        end else begin
            if (w_apply) begin
                r_act_int  <= r_sh_int;
                r_act_frac <= r_sh_frac;
            end
            if (i_load) begin
                r_sh_int  <= w_ld_int;
                r_sh_frac <= i_div_frac;
                r_pending <= 1'b1;
            end else if (w_apply) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Period counter, fractional accumulator and oversample divider.
    // A resync restarts the bit phase at mid-bit so that RX samples fall at bit centres.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_cnt      <= DEF_INT - INT_NBITS'(1);
            r_acc      <= '0;
            r_os       <= OS_LAST;
            r_tick     <= 1'b0;
            r_bit_tick <= 1'b0;
        end else begin
            r_tick     <= 1'b0;
            r_bit_tick <= 1'b0;
            if (i_resync) begin
                r_cnt <= w_start_cnt;
                r_acc <= '0;
                r_os  <= OS_HALF;
            end else if (!i_enable) begin
                if (r_pending) begin
                    r_cnt <= w_start_cnt;
                    r_acc <= '0;
                end
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - INT_NBITS'(1);
            end else begin
                r_tick <= 1'b1;
                r_acc  <= w_sum[FRAC_NBITS-1:0];
                r_cnt  <= w_reload_cnt;
                if (r_os == '0) begin
                    r_os       <= OS_LAST;
                    r_bit_tick <= 1'b1;
                end else begin
                    r_os <= r_os - OS_NBITS'(1);
                end
            end
        end
    end

    assign o_tick     = r_tick;
    assign o_bit_tick = r_bit_tick;
    assign o_pending  = r_pending;

endmodule

// File: tb/tb_br_gen_frac.sv
// Bench for br_gen_frac: table of divisor cases, hand-written corner sequences and
// randomized traffic. Every cycle is also checked against an arithmetic reference model.
module tb_br_gen_frac;

    localparam int DEF_INT = 162;
    localparam int DEF_FRAC = 12;
    localparam int OS = 16;
    localparam int FB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        ld = 1'b0;
    logic        rs = 1'b0;
    logic [11:0] di = '0;
    logic [3:0]  df = '0;
    logic        o_tick, o_bit_tick, o_pending;

    int errors = 0;
    int checks = 0;

    br_gen_frac dut (
        .i_clock(clk), .i_reset(rst), .i_enable(en),
        .i_div_int(di), .i_div_frac(df), .i_load(ld), .i_resync(rs),
        .o_tick(o_tick), .o_bit_tick(o_bit_tick), .o_pending(o_pending)
    );

    always #5 clk = ~clk;

    // Reference model. Tick times come from the closed form for a fractional divider:
    // the k-th period of a phase is int + floor(k*frac/2^F) - floor((k-1)*frac/2^F).
    // Bit ticks occur whenever the count of ticks since the phase origin is a multiple of OS.
    int     m_int, m_frac, m_sh_int, m_sh_frac, m_rem, m_nbit;
    longint m_k;
    bit     m_pend, m_tick, m_bit;

    function automatic int period(int iv, int fv, longint k);
        return iv + int'((k * fv) >> FB) - int'(((k - 1) * fv) >> FB);
    endfunction

    task automatic m_apply();
        m_int  = m_sh_int;
        m_frac = m_sh_frac;
        m_pend = 0;
    endtask

    task automatic model_step();
        m_tick = 0;
        m_bit  = 0;
        if (rst) begin
            m_int = DEF_INT;  m_frac = DEF_FRAC;
            m_sh_int = DEF_INT;  m_sh_frac = DEF_FRAC;
            m_pend = 0;  m_rem = DEF_INT;  m_k = 1;  m_nbit = 0;
        end else begin
            if (rs) begin
                if (m_pend) m_apply();
                m_rem = m_int;  m_k = 1;  m_nbit = OS / 2;
            end else if (!en) begin
                if (m_pend) begin
                    m_apply();
                    m_rem = m_int;  m_k = 1;
                end
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    m_tick = 1;
                    m_nbit++;
                    m_bit = (m_nbit % OS) == 0;
                    if (m_pend) begin
                        m_apply();
                        m_k = 1;
                    end
                    m_rem = period(m_int, m_frac, m_k);
                    m_k++;
                end
            end
            if (ld) begin
                m_sh_int  = (int'(di) < 2) ? 2 : int'(di);
                m_sh_frac = int'(df);
                m_pend    = 1;
            end
        end
    endtask

    task automatic chk(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // One clock: model and DUT see the same inputs, outputs compared at the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        checks++;
        if ({o_tick, o_bit_tick, o_pending} !== {m_tick, m_bit, m_pend}) begin
            errors++;
            $display("FAIL model_cmp t=%0t: tick/bit/pend got %b%b%b expected %b%b%b",
                     $time, o_tick, o_bit_tick, o_pending, m_tick, m_bit, m_pend);
        end
    endtask

    task automatic wait_tick(input int budget, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!o_tick && n < budget);
        checks++;
        if (!o_tick) begin
            errors++;
            $display("FAIL tick_timeout: got no tick within %0d cycles", budget);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;  cyc();  rst = 1'b0;
    endtask

    task automatic load(input int iv, input int fv);
        di = 12'(iv);  df = 4'(fv);  ld = 1'b1;  cyc();  ld = 1'b0;
    endtask

    typedef struct {
        int din;
        int fin;
        int exp_min;
        int exp_max;
        int exp_sum16;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n, sum, lng, bits, bitpos, mn, mx;
        int exp_alt[4];

        vecs[0] = '{10, 0, 10, 10, 160};
        vecs[1] = '{1, 8, 2, 3, 40};
        vecs[2] = '{0, 15, 2, 3, 47};
        vecs[3] = '{5, 1, 5, 6, 81};
        vecs[4] = '{100, 3, 100, 101, 1603};
        vecs[5] = '{33, 15, 33, 34, 543};

        // Reset state and default rate.
        @(negedge clk);
        rst = 1'b1;  cyc();  cyc();
        chk("reset_outputs", int'({o_tick, o_bit_tick, o_pending}), 0);
        rst = 1'b0;  en = 1'b1;
        wait_tick(400, n);
        chk("first_tick_delay", n, 162);
        chk("first_tick_no_bit", int'(o_bit_tick), 0);
        sum = 0;  lng = 0;  bits = 0;  bitpos = 0;
        for (int i = 2; i <= 17; i++) begin
            wait_tick(400, n);
            sum += n;
            if (n == 163) lng++;
            else if (n != 162) chk("default_period_range", n, 162);
            if (o_bit_tick) begin bits++; bitpos = i; end
        end
        chk("default_sum16", sum, 2604);
        chk("default_long_periods", lng, 12);
        chk("default_bit_count", bits, 1);
        chk("default_bit_position", bitpos, 16);

        // Load (10,0) mid-period; old period completes, then exact 10.
        repeat (50) cyc();
        load(10, 0);
        chk("load_pending_rise", int'(o_pending), 1);
        wait_tick(400, n);
        chk("load_pending_clear", int'(o_pending), 0);
        for (int i = 0; i < 5; i++) begin
            wait_tick(100, n);
            chk("div10_period", n, 10);
        end

        // Two loads while pending: the last one (1,8 -> clamped 2) wins.
        repeat (3) cyc();
        load(7, 0);
        load(1, 8);
        wait_tick(100, n);
        exp_alt = '{2, 3, 2, 3};
        for (int i = 0; i < 4; i++) begin
            wait_tick(100, n);
            chk("clamp_alt_period", n, exp_alt[i]);
        end

        // Enable dropped for 37 cycles delays the tick by exactly 37.
        load(50, 0);
        wait_tick(100, n);
        wait_tick(100, n);
        chk("div50_period", n, 50);
        repeat (10) cyc();
        en = 1'b0;
        bits = 0;
        for (int i = 0; i < 37; i++) begin
            cyc();
            bits += int'(o_tick) + int'(o_bit_tick);
        end
        chk("disabled_no_ticks", bits, 0);
        en = 1'b1;
        wait_tick(200, n);
        chk("enable_resume_remaining", n, 40);

        // Resync on the reload cycle: no tick, then mid-bit phase.
        repeat (49) cyc();
        rs = 1'b1;  cyc();  rs = 1'b0;
        chk("resync_no_tick", int'(o_tick), 0);
        wait_tick(200, n);
        chk("resync_first_period", n, 50);
        bitpos = o_bit_tick ? 1 : 0;
        for (int i = 2; i <= 10; i++) begin
            wait_tick(200, n);
            if (o_bit_tick && bitpos == 0) bitpos = i;
        end
        chk("resync_bit_position", bitpos, 8);

        // Reset while a load is pending reverts to defaults.
        repeat (7) cyc();
        load(10, 0);
        repeat (5) cyc();
        chk("pending_before_reset", int'(o_pending), 1);
        do_reset();
        chk("pending_after_reset", int'(o_pending), 0);
        wait_tick(400, n);
        chk("reset_first_tick", n, 162);
        wait_tick(400, n);
        chk("reset_second_period", n, 162);

        // Table of divisors: 16-period sum plus min/max period.
        foreach (vecs[v]) begin
            do_reset();
            load(vecs[v].din, vecs[v].fin);
            wait_tick(400, n);
            sum = 0;  mn = 1 << 30;  mx = 0;
            for (int i = 0; i < 16; i++) begin
                wait_tick(400, n);
                sum += n;
                if (n < mn) mn = n;
                if (n > mx) mx = n;
            end
            chk("table_sum16", sum, vecs[v].exp_sum16);
            chk("table_min_period", mn, vecs[v].exp_min);
            chk("table_max_period", mx, vecs[v].exp_max);
        end

        // Randomized traffic checked against the model each cycle.
        for (int i = 0; i < 6000; i++) begin
            rst = ($urandom_range(0, 999) == 0);
            en  = ($urandom_range(0, 7) != 0);
            ld  = ($urandom_range(0, 39) == 0);
            rs  = ($urandom_range(0, 149) == 0);
            di  = 12'($urandom_range(0, 23));
            df  = 4'($urandom_range(0, 15));
            cyc();
        end
        rst = 1'b0;  en = 1'b0;  ld = 1'b0;  rs = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
